// File: rtl/instr_fetch_pkg.sv
// Shared pipeline package: default widths for the fetch stage and the
// pipeline-register modules, plus the NOP encoding presented on bubbles.
package instr_fetch_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 8;
    localparam int DEPTH_DEF   = 2;

    // Instruction word shown downstream whenever no valid instruction exists.
    localparam logic [7:0] NOP_INSTR = 8'h00;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of an index into an n-entry array.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch buffer holding (instruction, pc) pairs.
// Ports:
//   clk, reset       clock, async active-low reset
//   flush            empties the buffer; wins over push/pop
//   push, push_data, push_pc   write one entry (dropped when full and not popping)
//   pop              remove head entry (ignored when empty)
//   head_data, head_pc         current head entry (undefined when empty)
//   full, empty, count         occupancy status
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DW    = INSTR_W_DEF,
    parameter int AW    = PC_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] head_pc,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = ptr_w(DEPTH);

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] pc_q   [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer can still take a push when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            data_q[wr_ptr] <= push_data;
            pc_q[wr_ptr]   <= push_pc;
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_pc   = pc_q[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage with a small prefetch buffer.
// Issues sequential fetch requests to instruction memory, matches in-order
// responses with their PCs and presents the buffered head to the IF/ID register.
// Ports:
//   clk, reset                 clock, async active-low reset
//   stall                      IF/ID not accepting; head is held
//   redirect, redirect_pc      restart fetch at redirect_pc, flush everything
//   imem_req/imem_addr/imem_gnt      request handshake
//   imem_rvalid/imem_rdata           in-order response, no back-pressure
//   instruction/instr_valid/instr_pc head of the prefetch buffer (NOP/0 when empty)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    instr_pc
);

    localparam int CNT_W = cnt_w(DEPTH);
    // Repeated redirects can stack stale responses beyond DEPTH.
    localparam int DSC_W = CNT_W + 2;
    localparam int PTR_W = ptr_w(DEPTH);

    logic [PC_W-1:0]    pc;
    logic [CNT_W-1:0]   outstanding;
    logic [DSC_W-1:0]   discard, discard_nxt, dsc_sum;
    logic [PC_W-1:0]    aq_pc [DEPTH];
    logic [PTR_W-1:0]   aq_wr, aq_rd;

    logic               pop, accept, rsp_take, rsp_discard;
    logic [CNT_W-1:0]   occupancy, occ_eff;
    logic               fifo_full, fifo_empty;
    logic [INSTR_W-1:0] head_data;
    logic [PC_W-1:0]    head_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Redirect outranks stall: the head is flushed, not consumed.
    assign pop     = instr_valid && !stall && !redirect;
    // Count a slot leaving this cycle as free so that straight-line fetch
    // sustains one instruction per cycle with a two-entry buffer.
    assign occ_eff = occupancy - CNT_W'(pop);

    // Gating with reset keeps the request low while reset is held.
    assign imem_req  = reset && !redirect &&
                       (({1'b0, occ_eff} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;

    // Stale responses (from before a redirect) are consumed first.
    assign rsp_discard = imem_rvalid && !redirect && (discard != '0);
    assign rsp_take    = imem_rvalid && !redirect && (discard == '0) && (outstanding != '0);

    // On redirect every outstanding request becomes stale; a response landing
    // in the redirect cycle itself is already one of those and is retired here.
    always_comb begin
        dsc_sum     = discard + DSC_W'(outstanding);
        discard_nxt = dsc_sum;
        if (imem_rvalid && (dsc_sum != '0)) discard_nxt = dsc_sum - DSC_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            outstanding <= '0;
            discard     <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else if (redirect) begin
            pc          <= redirect_pc;
            outstanding <= '0;
            discard     <= discard_nxt;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            if (accept) begin
                pc    <= pc + PC_W'(1);
                aq_wr <= ptr_inc(aq_wr);
            end
            if (rsp_take) aq_rd <= ptr_inc(aq_rd);
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_take);
            if (rsp_discard) discard <= discard - DSC_W'(1);
        end
    end

    // PC of each accepted request, consumed in order by its response.
    always_ff @(posedge clk) begin
        if (accept) aq_pc[aq_wr] <= pc;
    end

    fetch_fifo #(
        .DW   (INSTR_W),
        .AW   (PC_W),
        .DEPTH(DEPTH),
        .CW   (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push     (rsp_take),
        .push_data(imem_rdata),
        .push_pc  (aq_pc[aq_rd]),
        .pop      (pop),
        .head_data(head_data),
        .head_pc  (head_pc),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (occupancy)
    );

    assign instr_valid = !fifo_empty;
    assign instruction = fifo_empty ? INSTR_W'(NOP_INSTR) : head_data;
    assign instr_pc    = fifo_empty ? '0 : head_pc;

    // A response into a full buffer is a memory protocol error; data is dropped.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_take && fifo_full && !pop));
    // A response with nothing requested is likewise a protocol error.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && !redirect && (discard == '0) && (outstanding == '0)));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch. A memory model answers
// granted requests in order with data = addr + 8'h10; the reference model
// tracks the expected linear fetch stream per redirect epoch.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0, reset = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [7:0] redirect_pc = '0;
    logic       imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [7:0] imem_addr, imem_rdata = '0;
    logic [7:0] instruction, instr_pc;
    logic       instr_valid;

    always #5 clk = ~clk;

    instr_fetch #(.PC_W(8), .INSTR_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc)
    );

    typedef struct { logic [7:0] addr; int due; int epoch; } mem_t;
    typedef struct { logic [7:0] pc; logic [7:0] data; } exp_t;
    mem_t mq[$];
    exp_t sb[$];

    int tests = 0, fails = 0, cyc = 0, epoch = 0, occ = 0, delivered = 0, last_due = 0;
    int gnt_pct = 100, lat_min = 1, lat_max = 1, stall_pct = 0, redir_pct = 0;
    bit gnt_pattern = 0, in_reset = 1, first_after_reset = 0, hold_chk = 0;
    logic [7:0] model_pc = '0, hold_i, hold_pc;

    function automatic logic [7:0] memf(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, check/update model 1ns later.
    task automatic step(input bit force_rd = 0, input logic [7:0] rpc = 8'h00);
        bit   rd;
        int   cur, lat, due;
        mem_t rsp;
        rd          = force_rd || ($urandom_range(99) < redir_pct);
        redirect    = rd;
        redirect_pc = force_rd ? rpc : 8'($urandom);
        stall       = ($urandom_range(99) < stall_pct);
        imem_gnt    = gnt_pattern ? ((cyc % 4) == 0 || (cyc % 4) == 3)
                                  : ($urandom_range(99) < gnt_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mq[0].addr);
        end
        #1;
        chk("instr_valid_vs_model", instr_valid, occ > 0);
        if (rd) chk("req_low_in_redirect", imem_req, 0);
        if (stall && occ == DEPTH) chk("req_low_when_full", imem_req, 0);
        if (imem_req) chk("imem_addr", imem_addr, model_pc);
        if (first_after_reset) begin
            chk("first_req_after_reset", {imem_req, imem_addr}, 9'h100);
            first_after_reset = 0;
        end
        if (imem_rvalid) begin
            rsp = mq.pop_front();
            if (!rd && rsp.epoch == epoch) occ++;
        end
        if (occ > 0 && !stall && !rd && !imem_rvalid) occ--;
        else if (occ > 1 && !stall && !rd && imem_rvalid) occ--;
        if (imem_req && imem_gnt) begin
            lat = $urandom_range(lat_max, lat_min);
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = due;
            mq.push_back('{imem_addr, due, epoch});
            sb.push_back('{model_pc, memf(model_pc)});
            model_pc = model_pc + 8'd1;
        end
        if (rd) begin
            epoch++;
            occ = 0;
            sb.delete();
            model_pc = redirect_pc;
        end
        cur = 0;
        foreach (mq[i]) if (mq[i].epoch == epoch) cur++;
        chk("occ_plus_outstanding_le_depth", (occ + cur) <= DEPTH, 1);
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        in_reset    = 1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_imem_addr", imem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        sb.delete();
        occ = 0;
        model_pc = '0;
        epoch++;
        last_due = cyc;
        first_after_reset = 1;
        in_reset = 0;
    endtask

    // Monitor: compares every instruction the DUT hands downstream.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (in_reset || !reset) begin
            hold_chk = 0;
        end else begin
            if (hold_chk) begin
                chk("stall_hold_valid", instr_valid, 1);
                chk("stall_hold_instr", instruction, hold_i);
                chk("stall_hold_pc", instr_pc, hold_pc);
            end
            hold_chk = instr_valid && stall && !redirect;
            hold_i   = instruction;
            hold_pc  = instr_pc;
            if (!instr_valid) begin
                chk("empty_instr_nop", instruction, 0);
                chk("empty_instr_pc", instr_pc, 0);
            end else if (!stall && !redirect) begin
                if (sb.size() == 0) begin
                    chk("unexpected_delivery_sb_size", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("deliver_pc", instr_pc, e.pc);
                    chk("deliver_instr", instruction, e.data);
                    delivered++;
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Straight-line: one instruction per cycle once the pipe fills.
        for (int i = 0; i < 16; i++) begin
            if (i >= 2) chk("straight_back_to_back", instr_valid, 1);
            step();
        end

        // Stall held four cycles, then resume.
        stall_pct = 100;
        for (int i = 0; i < 4; i++) step();
        stall_pct = 0;
        for (int i = 0; i < 6; i++) step();

        // Redirect with outstanding requests in flight.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 8; i++) step();
        step(1, 8'h40);
        for (int i = 0; i < 12; i++) step();

        // PC wrap through 8'hFF.
        lat_min = 1; lat_max = 1;
        step(1, 8'hFE);
        for (int i = 0; i < 10; i++) step();

        // Grant gaps 1,0,0,1 with latency 3.
        gnt_pattern = 1; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40; i++) step();
        gnt_pattern = 0;

        // Random mix.
        gnt_pct = 60; lat_min = 1; lat_max = 4; stall_pct = 30; redir_pct = 5;
        for (int i = 0; i < 600; i++) step();

        // Reset mid-stream, then straight-line restart from address 0.
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; stall_pct = 0; redir_pct = 0;
        for (int i = 0; i < 30; i++) step();

        chk("enough_deliveries", delivered > 100, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
